ofm_wb: RTL and testbench



---
 rtl/ofm_wb.sv | 159 +++++++++++++++
 tb/tb_ofm_wb.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_wb.sv
// OFM write-back: joins the DMA data beats with the OFM address stream and issues one registered SRAM write per joined beat.
// Optional build macro OFM_WB_RELU_EN clamps negative two's-complement lanes to zero before the write register.
module ofm_wb #(
  parameter int DW = 8,
  parameter int DN = 6,
  parameter int AW = 14,
  parameter int CW = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DN*DW-1:0]   wd_m_data,
  input  logic               wd_m_first,
  input  logic               wd_m_last,
  input  logic               wd_m_valid,
  output logic               wd_m_ready,
  input  logic [AW-1:0]      ad_m_addr,
  input  logic               ad_m_first,
  input  logic               ad_m_last,
  input  logic               ad_m_valid,
  output logic               ad_m_ready,
  output logic               sram_cs,
  output logic               sram_we,
  output logic [AW-1:0]      sram_addr,
  output logic [DN*DW-1:0]   sram_wdata,
  output logic [CW-1:0]      done_cnt,
  output logic               done_err,
  output logic               done_valid,
  input  logic               done_ready
);

  // state | meaning
  // IDLE  | waiting for a joint first beat
  // RUN   | inside a frame, writing joined beats
  // DRAIN | framing error, consuming each stream up to its last beat
  // DONE  | completion offered on done_*
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt, cnt_inc;
  logic             err, err_nxt;
  logic             wd_seen, wd_seen_nxt;
  logic             ad_seen, ad_seen_nxt;
  logic             joint;
  logic             wr_fire;
  logic [DN*DW-1:0] wdata_mod;

  assign joint   = wd_m_valid & ad_m_valid;
  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

  always_comb begin
    wdata_mod = wd_m_data;
`ifdef OFM_WB_RELU_EN
    for (int i = 0; i < DN; i++) begin
      if (wd_m_data[i*DW + DW-1]) wdata_mod[i*DW +: DW] = '0;
    end
`endif
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    err_nxt     = err;
    wd_seen_nxt = wd_seen;
    ad_seen_nxt = ad_seen;
    wd_m_ready  = 1'b0;
    ad_m_ready  = 1'b0;
    wr_fire     = 1'b0;
    done_valid  = 1'b0;
    case (state)
      IDLE: begin
        wd_m_ready = joint;
        ad_m_ready = joint;
        if (joint) begin
          if (wd_m_first && ad_m_first && (wd_m_last == ad_m_last)) begin
            wr_fire   = 1'b1;
            cnt_nxt   = CW'(1);
            state_nxt = wd_m_last ? DONE : RUN;
          end else begin
            err_nxt     = 1'b1;
            wd_seen_nxt = wd_m_last;
            ad_seen_nxt = ad_m_last;
            state_nxt   = DRAIN;
          end
        end
      end
      RUN: begin
        wd_m_ready = joint;
        ad_m_ready = joint;
        if (joint) begin
          if (!wd_m_first && !ad_m_first && (wd_m_last == ad_m_last)) begin
            wr_fire   = 1'b1;
            cnt_nxt   = cnt_inc;
            state_nxt = wd_m_last ? DONE : RUN;
          end else begin
            err_nxt     = 1'b1;
            wd_seen_nxt = wd_m_last;
            ad_seen_nxt = ad_m_last;
            state_nxt   = DRAIN;
          end
        end
      end
      DRAIN: begin
        // each stream is swallowed independently until its own last beat
        wd_m_ready = !wd_seen;
        ad_m_ready = !ad_seen;
        if (wd_m_valid && !wd_seen && wd_m_last) wd_seen_nxt = 1'b1;
        if (ad_m_valid && !ad_seen && ad_m_last) ad_seen_nxt = 1'b1;
        if (wd_seen_nxt && ad_seen_nxt) state_nxt = DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        if (done_ready) begin
          cnt_nxt     = '0;
          err_nxt     = 1'b0;
          wd_seen_nxt = 1'b0;
          ad_seen_nxt = 1'b0;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      err     <= 1'b0;
      wd_seen <= 1'b0;
      ad_seen <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      err     <= err_nxt;
      wd_seen <= wd_seen_nxt;
      ad_seen <= ad_seen_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_cs    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      sram_cs <= wr_fire;
      sram_we <= wr_fire;
      if (wr_fire) begin
        sram_addr  <= ad_m_addr;
        sram_wdata <= wdata_mod;
      end
    end
  end

  assign done_cnt = cnt;
  assign done_err = err;

endmodule

// File: tb/tb_ofm_wb.sv
// Directed bench for ofm_wb: framed joins, sparse address stream, drain on misalignment, single beat, reset mid-frame, ReLU.
module tb_ofm_wb;
  localparam int DW = 8;
  localparam int DN = 6;
  localparam int AW = 14;
  localparam int CW = 10;
  localparam logic [DN*DW-1:0] D0 = 48'h010203040506;

  logic              clk, rst;
  logic [DN*DW-1:0]  wd_m_data;
  logic              wd_m_first, wd_m_last, wd_m_valid, wd_m_ready;
  logic [AW-1:0]     ad_m_addr;
  logic              ad_m_first, ad_m_last, ad_m_valid, ad_m_ready;
  logic              sram_cs, sram_we;
  logic [AW-1:0]     sram_addr;
  logic [DN*DW-1:0]  sram_wdata;
  logic [CW-1:0]     done_cnt;
  logic              done_err, done_valid, done_ready;

  int vectors = 0;
  int miscompares = 0;
  int k, cyc;
  logic av;
  logic [DN*DW-1:0] relu_in, relu_exp;

  ofm_wb #(.DW(DW), .DN(DN), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .wd_m_data(wd_m_data), .wd_m_first(wd_m_first), .wd_m_last(wd_m_last),
    .wd_m_valid(wd_m_valid), .wd_m_ready(wd_m_ready),
    .ad_m_addr(ad_m_addr), .ad_m_first(ad_m_first), .ad_m_last(ad_m_last),
    .ad_m_valid(ad_m_valid), .ad_m_ready(ad_m_ready),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .done_cnt(done_cnt), .done_err(done_err), .done_valid(done_valid), .done_ready(done_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic wv, input logic [DN*DW-1:0] wd, input logic wf, input logic wl,
                     input logic avl, input logic [AW-1:0] aa, input logic af, input logic al);
    wd_m_valid = wv; wd_m_data = wd; wd_m_first = wf; wd_m_last = wl;
    ad_m_valid = avl; ad_m_addr = aa; ad_m_first = af; ad_m_last = al;
  endtask

  task automatic idle_inputs();
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ack_done(input string tag);
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    chk1({tag, "_done_cleared"}, done_valid, 1'b0);
    chkw({tag, "_cnt_cleared"}, 64'(done_cnt), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    done_ready = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("rst_cs", sram_cs, 1'b0);
    chk1("rst_we", sram_we, 1'b0);
    chkw("rst_addr", 64'(sram_addr), 64'(0));
    chkw("rst_wdata", 64'(sram_wdata), 64'(0));
    chkw("rst_cnt", 64'(done_cnt), 64'(0));
    chk1("rst_err", done_err, 1'b0);
    chk1("rst_done", done_valid, 1'b0);
    chk1("rst_wd_ready", wd_m_ready, 1'b0);
    chk1("rst_ad_ready", ad_m_ready, 1'b0);
    @(negedge clk);

    // 1: four-beat frame, both streams always valid
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 48'(D0 + i), i == 0, i == 3, 1'b1, 14'(14'h100 + i), i == 0, i == 3);
      #1;
      chk1("t1_wd_ready", wd_m_ready, 1'b1);
      chk1("t1_ad_ready", ad_m_ready, 1'b1);
      chk1("t1_cs_before", sram_cs, (i != 0));
      step();
      chk1("t1_cs", sram_cs, 1'b1);
      chk1("t1_we", sram_we, 1'b1);
      chkw("t1_addr", 64'(sram_addr), 64'(14'h100 + i));
      chkw("t1_wdata", 64'(sram_wdata), 64'(48'(D0 + i)));
    end
    idle_inputs();
    chk1("t1_done_valid", done_valid, 1'b1);
    chkw("t1_done_cnt", 64'(done_cnt), 64'(4));
    chk1("t1_done_err", done_err, 1'b0);
    ack_done("t1");
    chk1("t1_cs_idle", sram_cs, 1'b0);
    chkw("t1_addr_hold", 64'(sram_addr), 64'(14'h103));

    // 2: address stream valid every third cycle, delayed done_ready
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 30) begin
      av = (cyc % 3 == 2);
      drv(1'b1, 48'(D0 + k), k == 0, k == 3, av, 14'(14'h100 + k), k == 0, k == 3);
      step();
      chk1("t2_cs", sram_cs, av);
      if (av) begin
        chkw("t2_addr", 64'(sram_addr), 64'(14'h100 + k));
        chkw("t2_wdata", 64'(sram_wdata), 64'(48'(D0 + k)));
        k++;
      end
      cyc++;
    end
    chkw("t2_beats_joined", 64'(k), 64'(4));
    chkw("t2_cycles_used", 64'(cyc), 64'(12));
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 48'h0000000000AA, 1'b1, 1'b0, 1'b1, 14'h200, 1'b1, 1'b0);
      #1;
      chk1("t2_hold_wd_ready", wd_m_ready, 1'b0);
      chk1("t2_hold_ad_ready", ad_m_ready, 1'b0);
      chk1("t2_hold_valid", done_valid, 1'b1);
      chkw("t2_hold_cnt", 64'(done_cnt), 64'(4));
      chk1("t2_hold_err", done_err, 1'b0);
      step();
      chk1("t2_hold_cs", sram_cs, 1'b0);
    end
    idle_inputs();
    ack_done("t2");

    // 3: data last on beat 3, address last on beat 5
    for (int i = 0; i < 2; i++) begin
      drv(1'b1, 48'(D0 + i), i == 0, 1'b0, 1'b1, 14'(14'h300 + i), i == 0, 1'b0);
      step();
      chk1("t3_cs", sram_cs, 1'b1);
      chkw("t3_addr", 64'(sram_addr), 64'(14'h300 + i));
    end
    drv(1'b1, 48'(D0 + 2), 1'b0, 1'b1, 1'b1, 14'h302, 1'b0, 1'b0);
    #1;
    chk1("t3_bad_wd_ready", wd_m_ready, 1'b1);
    step();
    chk1("t3_bad_not_written", sram_cs, 1'b0);
    chkw("t3_addr_hold", 64'(sram_addr), 64'(14'h301));
    chk1("t3_drain_wd_ready", wd_m_ready, 1'b0);
    chk1("t3_drain_ad_ready", ad_m_ready, 1'b1);
    drv(1'b0, '0, 1'b0, 1'b0, 1'b1, 14'h303, 1'b0, 1'b0);
    step();
    chk1("t3_drain_cs", sram_cs, 1'b0);
    chk1("t3_drain_not_done", done_valid, 1'b0);
    drv(1'b0, '0, 1'b0, 1'b0, 1'b1, 14'h304, 1'b0, 1'b1);
    #1;
    chk1("t3_drain_last_ready", ad_m_ready, 1'b1);
    step();
    idle_inputs();
    chk1("t3_drain_cs2", sram_cs, 1'b0);
    chk1("t3_done_valid", done_valid, 1'b1);
    chkw("t3_done_cnt", 64'(done_cnt), 64'(2));
    chk1("t3_done_err", done_err, 1'b1);
    ack_done("t3");
    chk1("t3_err_cleared", done_err, 1'b0);

    // 4: single-beat frame at top address
    drv(1'b1, 48'h0A0B0C0D0E0F, 1'b1, 1'b1, 1'b1, 14'h3FFF, 1'b1, 1'b1);
    step();
    idle_inputs();
    chk1("t4_cs", sram_cs, 1'b1);
    chkw("t4_addr", 64'(sram_addr), 64'(14'h3FFF));
    chkw("t4_wdata", 64'(sram_wdata), 64'(48'h0A0B0C0D0E0F));
    chk1("t4_done_valid", done_valid, 1'b1);
    chkw("t4_done_cnt", 64'(done_cnt), 64'(1));
    chk1("t4_done_err", done_err, 1'b0);
    step();
    chk1("t4_cs_once", sram_cs, 1'b0);
    ack_done("t4");

    // 5: reset right after the first handshake of a six-beat frame
    drv(1'b1, D0, 1'b1, 1'b0, 1'b1, 14'h500, 1'b1, 1'b0);
    step();
    chk1("t5_cs_pre", sram_cs, 1'b1);
    drv(1'b1, 48'(D0 + 1), 1'b0, 1'b0, 1'b1, 14'h501, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk1("t5_rst_cs", sram_cs, 1'b0);
    chk1("t5_rst_we", sram_we, 1'b0);
    chkw("t5_rst_cnt", 64'(done_cnt), 64'(0));
    idle_inputs();
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      drv(1'b1, 48'(D0 + 16 + i), i == 0, i == 1, 1'b1, 14'(14'h600 + i), i == 0, i == 1);
      #1;
      chk1("t5_wd_ready", wd_m_ready, 1'b1);
      step();
      chk1("t5_cs", sram_cs, 1'b1);
      chkw("t5_addr", 64'(sram_addr), 64'(14'h600 + i));
    end
    idle_inputs();
    chk1("t5_done_valid", done_valid, 1'b1);
    chkw("t5_done_cnt", 64'(done_cnt), 64'(2));
    chk1("t5_done_err", done_err, 1'b0);
    ack_done("t5");

    // 6: lane clamp (only with OFM_WB_RELU_EN)
    relu_in = 48'h807FFF0100C0;
`ifdef OFM_WB_RELU_EN
    relu_exp = 48'h007F00010000;
`else
    relu_exp = 48'h807FFF0100C0;
`endif
    drv(1'b1, relu_in, 1'b1, 1'b1, 1'b1, 14'h0042, 1'b1, 1'b1);
    step();
    idle_inputs();
    chk1("t6_cs", sram_cs, 1'b1);
    chkw("t6_addr", 64'(sram_addr), 64'(14'h0042));
    chkw("t6_wdata", 64'(sram_wdata), 64'(relu_exp));
    ack_done("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
